// File: rtl/v810_pkg.sv
// V810 prefetch: shared types and constants.
// Fetch FSM states and the default reset vector.
package v810_pkg;

    typedef enum logic [1:0] {
        PF_IDLE,
        PF_REQ,
        PF_DROP
    } pf_state_t;

    localparam logic [31:0] V810_RESET_PC = 32'hFFFF_FFF0;

endpackage

// File: rtl/v810_hwfifo.sv
// V810 prefetch: halfword circular FIFO.
// Up to two halfwords in and two out per cycle; head pair always visible.
module v810_hwfifo #(
    parameter int DEPTH = 8
) (
    input  logic                     CLK,
    input  logic                     RES,
    input  logic                     clr,
    input  logic [1:0]               push_n,
    input  logic [31:0]              push_data,
    input  logic [1:0]               pop_n,
    output logic [31:0]              head,
    output logic [$clog2(DEPTH):0]   occ
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] rd;
    logic [AW-1:0] wr;
    logic [AW-1:0] rd1;
    logic [AW-1:0] wr1;

    assign rd1  = rd + 1'b1;
    assign wr1  = wr + 1'b1;
    assign head = {mem[rd1], mem[rd]};

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            rd  <= '0;
            wr  <= '0;
            occ <= '0;
        end else if (clr) begin
            rd  <= '0;
            wr  <= '0;
            occ <= '0;
        end else begin
            rd  <= rd + AW'(pop_n);
            wr  <= wr + AW'(push_n);
            occ <= occ + OW'(push_n) - OW'(pop_n);
        end
    end

    // lane 0 of push_data is always the earlier halfword
    always_ff @(posedge CLK) begin
        if (!clr) begin
            if (push_n != 2'd0)
                mem[wr] <= push_data[15:0];
            if (push_n == 2'd2)
                mem[wr1] <= push_data[31:16];
        end
    end

endmodule

// File: rtl/v810_prefetch.sv
// V810 instruction prefetch queue: word fetch FSM feeding a halfword
// queue that presents the next 1-2 halfwords at Q_PC to the decoder.
module v810_prefetch
    import v810_pkg::*;
#(
    parameter int          DEPTH_HW = 8,
    parameter logic [31:0] RESET_PC = V810_RESET_PC
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        CE,
    output logic [31:0] IA,
    input  logic [31:0] ID,
    output logic        IREQ,
    input  logic        IACK,
    input  logic        FLUSH,
    input  logic [31:0] FLUSH_PC,
    output logic [31:0] Q_PC,
    output logic [31:0] Q_DATA,
    output logic [1:0]  Q_CNT,
    input  logic [1:0]  Q_POP
);

    localparam int OW = $clog2(DEPTH_HW) + 1;

    pf_state_t   state;
    logic [31:0] pend;
    logic        skip;
    logic [OW-1:0] occ;
    logic [OW-1:0] occ_nxt;
    logic [1:0]  push_n;
    logic [1:0]  pop_n;
    logic [31:0] push_data;
    logic [31:0] flush_fa;
    logic        take;
    logic        room;
    logic        unused_bit;

    assign unused_bit = FLUSH_PC[0];
    assign flush_fa   = {FLUSH_PC[31:2], 2'b00};

    assign take      = (state == PF_REQ) && IACK && !FLUSH;
    assign push_n    = (CE && take) ? (skip ? 2'd1 : 2'd2) : 2'd0;
    assign push_data = skip ? {ID[15:0], ID[31:16]} : ID;
    assign pop_n     = (CE && !FLUSH) ? Q_POP : 2'd0;
    assign occ_nxt   = occ + OW'(push_n) - OW'(pop_n);
    assign room      = occ_nxt <= OW'(DEPTH_HW - 2);
    assign Q_CNT     = (occ >= OW'(2)) ? 2'd2 : occ[1:0];

    v810_hwfifo #(.DEPTH(DEPTH_HW)) u_fifo (
        .CLK       (CLK),
        .RES       (RES),
        .clr       (CE && FLUSH),
        .push_n    (push_n),
        .push_data (push_data),
        .pop_n     (pop_n),
        .head      (Q_DATA),
        .occ       (occ)
    );

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state <= PF_IDLE;
            IREQ  <= 1'b0;
            IA    <= {RESET_PC[31:2], 2'b00};
            pend  <= {RESET_PC[31:2], 2'b00};
            skip  <= RESET_PC[1];
            Q_PC  <= {RESET_PC[31:1], 1'b0};
        end else if (CE) begin
            if (FLUSH) begin
                Q_PC <= {FLUSH_PC[31:1], 1'b0};
                skip <= FLUSH_PC[1];
                // an outstanding access cannot be withdrawn: park the address
                if (state != PF_IDLE && !IACK) begin
                    state <= PF_DROP;
                    pend  <= flush_fa;
                end else begin
                    state <= PF_REQ;
                    IREQ  <= 1'b1;
                    IA    <= flush_fa;
                end
            end else begin
                Q_PC <= Q_PC + {29'd0, Q_POP, 1'b0};
                unique case (state)
                    PF_IDLE: begin
                        if (room) begin
                            state <= PF_REQ;
                            IREQ  <= 1'b1;
                        end
                    end
                    PF_REQ: begin
                        if (IACK) begin
                            IA   <= IA + 32'd4;
                            skip <= 1'b0;
                            if (!room) begin
                                state <= PF_IDLE;
                                IREQ  <= 1'b0;
                            end
                        end
                    end
                    PF_DROP: begin
                        if (IACK) begin
                            state <= PF_REQ;
                            IA    <= pend;
                        end
                    end
                    default: begin
                        state <= PF_IDLE;
                        IREQ  <= 1'b0;
                    end
                endcase
            end
        end
    end

    a_pop_legal: assert property (@(posedge CLK) disable iff (RES)
        (CE && !FLUSH) |-> (Q_POP <= Q_CNT));
    a_ia_stable: assert property (@(posedge CLK) disable iff (RES)
        (IREQ && !IACK) |=> $stable(IA));
    a_occ_max: assert property (@(posedge CLK) disable iff (RES)
        occ <= OW'(DEPTH_HW));

endmodule
